// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and prefix-decoder state encoding.
// Also used by the word-entry/scoring counter downstream.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // Set-2 make codes for the keys the game cares about
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_B = 8'h32;
  localparam logic [7:0] KEY_C = 8'h21;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_E = 8'h24;
  localparam logic [7:0] KEY_F = 8'h2B;
  localparam logic [7:0] KEY_G = 8'h34;
  localparam logic [7:0] KEY_H = 8'h33;
  localparam logic [7:0] KEY_I = 8'h43;
  localparam logic [7:0] KEY_J = 8'h3B;
  localparam logic [7:0] KEY_K = 8'h42;
  localparam logic [7:0] KEY_L = 8'h4B;
  localparam logic [7:0] KEY_M = 8'h3A;
  localparam logic [7:0] KEY_N = 8'h31;
  localparam logic [7:0] KEY_O = 8'h44;
  localparam logic [7:0] KEY_P = 8'h4D;
  localparam logic [7:0] KEY_Q = 8'h15;
  localparam logic [7:0] KEY_R = 8'h2D;
  localparam logic [7:0] KEY_S = 8'h1B;
  localparam logic [7:0] KEY_T = 8'h2C;
  localparam logic [7:0] KEY_U = 8'h3C;
  localparam logic [7:0] KEY_V = 8'h2A;
  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_X = 8'h22;
  localparam logic [7:0] KEY_Y = 8'h35;
  localparam logic [7:0] KEY_Z = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_BACK  = 8'h66;

  // Pause sends E1 followed by seven more bytes that carry no key event
  localparam int unsigned PAUSE_SKIP = 7;
  localparam int unsigned SKIP_W     = 3;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_EXT     = 3'd1;
  localparam logic [ST_W-1:0] ST_BRK     = 3'd2;
  localparam logic [ST_W-1:0] ST_EXT_BRK = 3'd3;
  localparam logic [ST_W-1:0] ST_SKIP    = 3'd4;

  // Frame layout {stop, parity, data[7:0], start}; parity is odd over data+parity
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && ((^f[9:1]) == 1'b1) && (f[10] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: synchronise and filter the raw lines, deframe 11-bit frames,
// check start/parity/stop and discard stalled partial frames.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned TIMEOUT  = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err
);

  localparam int unsigned FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BC_W = 4;

  logic            clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic            filt_q, filt_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [BC_W-1:0] bcnt_q, bcnt_d;
  logic [9:0]      shift_q, shift_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      byte_q, byte_d;
  logic            strobe_q, strobe_d;
  logic            err_q, err_d;
  logic            fall_c;
  logic [10:0]     frame_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Glitch filter: level follows only after FILT_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  assign fall_c  = filt_q & ~filt_d;
  assign frame_c = {dat_sync_q, shift_q};

  always_comb begin
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    to_d     = to_q;
    byte_d   = byte_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    if (fall_c) begin
      to_d    = '0;
      shift_d = {dat_sync_q, shift_q[9:1]};
      if (bcnt_q == BC_W'(10)) begin
        bcnt_d = '0;
        if (frame_ok(frame_c)) begin
          strobe_d = 1'b1;
          byte_d   = frame_c[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bcnt_d = bcnt_q + BC_W'(1);
      end
    end else if (bcnt_q == '0) begin
      to_d = '0;
    end else if (to_q == TO_W'(TIMEOUT - 1)) begin
      // Stalled partial frame: drop it so the next start bit realigns
      to_d   = '0;
      bcnt_d = '0;
      err_d  = 1'b1;
    end else begin
      to_d = to_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      to_q     <= '0;
      byte_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      to_q     <= to_d;
      byte_q   <= byte_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_strobe = strobe_q;
  assign rx_err    = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: prefix decoding, held-key bitmap and one-cycle
// change events for the word-entry/scoring counter.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN  = 8,
  parameter int unsigned TIMEOUT   = 200000,
  parameter int unsigned KEY_W     = 128,
  parameter int unsigned EXT_EN    = 0,
  parameter int unsigned REPEAT_EN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [KEY_W-1:0] key_down,
  output logic [8:0]       last_change,
  output logic             key_valid,
  output logic             frame_err
);

  localparam int unsigned IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  logic [7:0]        rx_byte;
  logic              rx_strobe;
  logic              rx_err;

  logic [ST_W-1:0]   state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [KEY_W-1:0]  key_down_q, key_down_d;
  logic [8:0]        last_change_q, last_change_d;
  logic              key_valid_q, key_valid_d;

  logic              ev_c, brk_c, ext_c, clr_c, in_range_c;
  logic [IDX_W-1:0]  idx_c;

  ps2_rx_frame #(
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .rx_err    (rx_err)
  );

  assign in_range_c = (32'(rx_byte) < KEY_W);
  assign idx_c      = IDX_W'(rx_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      skip_q        <= '0;
      key_down_q    <= '0;
      last_change_q <= '0;
      key_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_q        <= skip_d;
      key_down_q    <= key_down_d;
      last_change_q <= last_change_d;
      key_valid_q   <= key_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    skip_d        = skip_q;
    key_down_d    = key_down_q;
    last_change_d = last_change_q;
    key_valid_d   = 1'b0;
    ev_c          = 1'b0;
    brk_c         = 1'b0;
    ext_c         = 1'b0;
    clr_c         = 1'b0;

    // Prefix decode: classify the byte, bitmap/event update follows below
    if (rx_err) begin
      state_d = ST_IDLE;
    end else if (rx_strobe) begin
      case (state_q)
        ST_IDLE: begin
          case (rx_byte)
            PS2_EXT:   state_d = ST_EXT;
            PS2_BRK:   state_d = ST_BRK;
            PS2_PAUSE: begin
              state_d = ST_SKIP;
              skip_d  = SKIP_W'(PAUSE_SKIP);
            end
            PS2_BAT:   clr_c = 1'b1;
            PS2_ACK, PS2_ECHO, PS2_RESEND, PS2_ERR0, PS2_ERR1: ;
            default:   ev_c = 1'b1;
          endcase
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (rx_byte == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else if ((rx_byte != PS2_EXT) && (rx_byte != PS2_PAUSE)) begin
            ev_c  = 1'b1;
            ext_c = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          ev_c    = 1'b1;
          brk_c   = 1'b1;
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          ev_c    = 1'b1;
          brk_c   = 1'b1;
          ext_c   = 1'b1;
        end
        ST_SKIP: begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q <= SKIP_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (clr_c) begin
      key_down_d = '0;
    end

    // Extended keys never touch the bitmap; only their reporting is optional
    if (ev_c) begin
      if (ext_c) begin
        if (EXT_EN != 0) begin
          last_change_d = {1'b1, rx_byte};
          key_valid_d   = 1'b1;
        end
      end else if (in_range_c) begin
        if (brk_c) begin
          key_down_d[idx_c] = 1'b0;
          last_change_d     = {1'b0, rx_byte};
          key_valid_d       = 1'b1;
        end else if (!key_down_q[idx_c] || (REPEAT_EN != 0)) begin
          key_down_d[idx_c] = 1'b1;
          last_change_d     = {1'b0, rx_byte};
          key_valid_d       = 1'b1;
        end
      end
    end
  end

  assign key_down    = key_down_q;
  assign last_change = last_change_q;
  assign key_valid   = key_valid_q;
  assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench: two trackers (extended events dropped / reported) share one
// PS/2 line; expected events are queued ahead of each frame and checked by monitors.
module tb_ps2_key_tracker;

  localparam int unsigned TO   = 2000;
  localparam int          HALF = 20;

  typedef struct packed {
    logic [8:0]   lc;
    logic [127:0] kd;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic [127:0] kd0, kd1;
  logic [8:0]   lc0, lc1;
  logic         kv0, kv1, fe0, fe1;

  int           checks = 0;
  int           failures = 0;
  int           err_exp = 0;
  int           err0_seen = 0;
  int           err1_seen = 0;
  logic         kv0_prev = 1'b0;
  logic         kv1_prev = 1'b0;
  logic [127:0] kd_exp = '0;
  ev_t          q0[$];
  ev_t          q1[$];
  ev_t          e0, e1;

  always #5 clk = ~clk;

  ps2_key_tracker #(.TIMEOUT(TO), .EXT_EN(0), .REPEAT_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_down(kd0), .last_change(lc0), .key_valid(kv0), .frame_err(fe0)
  );

  ps2_key_tracker #(.TIMEOUT(TO), .EXT_EN(1), .REPEAT_EN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_down(kd1), .last_change(lc1), .key_valid(kv1), .frame_err(fe1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors: pop one expected event per key_valid pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (kv0) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ev0_unexpected actual=%h required=none", lc0);
        end else begin
          e0 = q0.pop_front();
          chk("ev0_last_change", 128'(lc0), 128'(e0.lc));
          chk("ev0_key_down", kd0, e0.kd);
        end
      end
      if (kv0_prev) chk("kv0_single_cycle", 128'(kv0), 128'(0));
      if (fe0) err0_seen++;
    end
    kv0_prev = kv0 & rst_n;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (kv1) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ev1_unexpected actual=%h required=none", lc1);
        end else begin
          e1 = q1.pop_front();
          chk("ev1_last_change", 128'(lc1), 128'(e1.lc));
          chk("ev1_key_down", kd1, e1.kd);
        end
      end
      if (kv1_prev) chk("kv1_single_cycle", 128'(kv1), 128'(0));
      if (fe1) err1_seen++;
    end
    kv1_prev = kv1 & rst_n;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(posedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11);
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic push_both(input logic [8:0] lc);
    q0.push_back({lc, kd_exp});
    q1.push_back({lc, kd_exp});
  endtask

  task automatic checkpoint(input string name);
    chk({name, "_q0_drained"}, 128'(q0.size()), 128'(0));
    chk({name, "_q1_drained"}, 128'(q1.size()), 128'(0));
    chk({name, "_err0_count"}, 128'(err0_seen), 128'(err_exp));
    chk({name, "_err1_count"}, 128'(err1_seen), 128'(err_exp));
    chk({name, "_key_down0"}, kd0, kd_exp);
    chk({name, "_key_down1"}, kd1, kd_exp);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("rst_key_down", kd0 | kd1, 128'(0));
    chk("rst_last_change", 128'({lc0, lc1}), 128'(0));
    chk("rst_pulses", 128'({kv0, kv1, fe0, fe1}), 128'(0));
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Make then break of A
    kd_exp[28] = 1'b1; push_both(9'h01C);
    send(8'h1C);
    checkpoint("a_make");
    kd_exp[28] = 1'b0; push_both(9'h01C);
    send(8'hF0); send(8'h1C);
    checkpoint("a_break");

    // Typematic repeats of SPACE are suppressed
    kd_exp[41] = 1'b1; push_both(9'h029);
    send(8'h29); send(8'h29); send(8'h29);
    checkpoint("space_repeat");
    kd_exp[41] = 1'b0; push_both(9'h029);
    send(8'hF0); send(8'h29);
    checkpoint("space_break");

    // Extended make/break: only the EXT_EN=1 instance reports
    q1.push_back({9'h175, kd_exp});
    q1.push_back({9'h175, kd_exp});
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    checkpoint("ext_updown");

    // Bad parity after F0 must drop the break prefix
    send(8'hF0);
    err_exp++;
    send_bits(mk_frame(8'h66, 1'b1), 11);
    repeat (2 * HALF) @(posedge clk);
    checkpoint("parity_err");
    kd_exp[102] = 1'b1; push_both(9'h066);
    send(8'h66);
    checkpoint("back_make");

    // Stalled partial frame times out, then a clean frame decodes
    err_exp++;
    send_bits(mk_frame(8'h1C, 1'b0), 5);
    repeat (TO + 200) @(posedge clk);
    checkpoint("timeout");
    kd_exp[28] = 1'b1; push_both(9'h01C);
    send(8'h1C);
    checkpoint("after_timeout");

    // BAT clears the bitmap silently; Pause sequence produces nothing
    kd_exp[41] = 1'b1; push_both(9'h029);
    send(8'h29);
    checkpoint("hold_two");
    kd_exp = '0;
    send(8'hAA);
    checkpoint("bat_clear");
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    checkpoint("pause_skip");
    kd_exp[28] = 1'b1; push_both(9'h01C);
    send(8'h1C);
    checkpoint("idle_after_pause");

    // Asynchronous reset in the middle of a frame
    send_bits(mk_frame(8'h29, 1'b0), 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_key_down0", kd0, 128'(0));
    chk("midrst_key_down1", kd1, 128'(0));
    chk("midrst_last_change", 128'({lc0, lc1}), 128'(0));
    chk("midrst_pulses", 128'({kv0, kv1, fe0, fe1}), 128'(0));
    kd_exp = '0;
    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    kd_exp[41] = 1'b1; push_both(9'h029);
    send(8'h29);
    repeat (TO + 100) @(posedge clk);
    checkpoint("after_midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Keyboard front end for the typing game. Receives raw PS/2 clock/data, deframes scan-code bytes and decodes the E0/F0/E1 prefixes. Maintains a per-key pressed bitmap. Emits one-cycle change events (key_down, last_change, key_valid) in the form consumed by the word-entry/scoring counter downstream.

Parameters:
FILT_LEN, 8, consecutive equal samples of ps2_clk required to accept a level change
TIMEOUT, 200000, clk cycles without a ps2_clk falling edge before a partial frame is discarded (2 ms at 100 MHz)
KEY_W, 128, width of the key_down bitmap; only non-extended codes < KEY_W are tracked
EXT_EN, 0, 1 = report E0-prefixed events (last_change[8]=1); 0 = drop them silently
REPEAT_EN, 0, 1 = pulse key_valid on typematic repeat makes; 0 = suppress them

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous, active-low reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_data  in  1  raw PS/2 data, asynchronous
key_down  out  KEY_W  bit n = 1 while scan code n is held
last_change  out  9  {ext, code} of the most recent reported event
key_valid  out  1  one-cycle pulse; key_down/last_change already hold the new values in this cycle
frame_err  out  1  one-cycle pulse on a discarded frame (start/parity/stop error or timeout)

Behaviour:
- Reset (rst_n=0, async): key_down=0, last_change=0, key_valid=0, frame_err=0; prefix FSM=IDLE; bit counter=0; timeout counter=0. A reset mid-frame abandons the frame.
- Input conditioning: 2-FF synchroniser on both lines. ps2_clk filtered: the filtered level changes only after FILT_LEN identical synchronised samples. A filtered 1->0 transition is a sample strobe; ps2_data is captured on that cycle.
- Framing: 11 bits: start=0, 8 data LSB first, odd parity, stop=1. Bit counter runs 0..10.
- Frame check: on bit 10, check start==0, parity (XOR of 8 data bits and parity bit ==1), stop==1. Pass -> byte strobe 1 cycle later. Fail -> frame_err pulse, no byte, prefix FSM forced to IDLE.
- Timeout: counter clears on every sample strobe and holds at 0 while bit counter==0. Reaching TIMEOUT with bit counter !=0 -> bit counter=0 and frame_err pulse. A strobe completing bit 10 in the same cycle as the timeout wins (frame accepted).
- Prefix FSM, advanced on each byte strobe:
  IDLE: E0->EXT; F0->BRK; E1->SKIP (skip count=7); AA->clear key_down, no event; FA/EE/FE/00/FF->ignored; other->make(ext=0).
  EXT: F0->EXT_BRK; E0/E1->IDLE (protocol error, no event); other->make(ext=1), ->IDLE.
  BRK: any->break(ext=0), ->IDLE.
  EXT_BRK: any->break(ext=1), ->IDLE.
  SKIP: decrement per byte; ->IDLE when the count reaches 0 (Pause sequence, no event).
- Make (ext=0, code<KEY_W): if the bit is clear -> set it, last_change={0,code}, key_valid. If the bit is already set -> report only when REPEAT_EN=1.
- Break (ext=0, code<KEY_W): clear the bit, last_change={0,code}, key_valid. A break of a key not held is still reported.
- ext=1 events: bitmap untouched. Reported (last_change={1,code}, key_valid) only when EXT_EN=1.
- Non-extended code >= KEY_W: no bitmap change, no event.
- Latency: byte strobe -> key_valid is exactly 1 cycle. key_valid is at most one pulse per byte and never asserted in two consecutive cycles.

Decomposition:
- Shared package ps2_pkg: scan-code constants (PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA, letter/SPACE=29/BACK=66 codes shared with the scoring counter), prefix FSM state encoding, and the PAUSE_SKIP=7 constant.
- One sub-module: ps2_rx_frame (synchroniser, filter, edge detect, shift register, parity/timeout). Outputs rx_byte[7:0], rx_strobe and rx_err to the prefix FSM/bitmap logic in ps2_key_tracker.

Test Plan:
- Frames 1C, F0, 1C (parities 0,1,0) -> after 1C: key_down[28]=1, last_change=01C, key_valid single pulse; after F0 1C: key_down[28]=0, second pulse, last_change=01C.
- 29 sent three times, then F0 29, REPEAT_EN=0 -> exactly 2 key_valid pulses total; key_down[41]=1 between them.
- EXT_EN=0, bytes E0 75 E0 F0 75 -> no key_valid, key_down unchanged. Rerun with EXT_EN=1 -> two pulses, last_change=175, key_down unchanged.
- Frame 66 with the parity bit flipped -> frame_err pulse, no key_valid, FSM IDLE; the following valid 66 -> key_down[102]=1 with one pulse.
- 5 bits of a frame then a silence of TIMEOUT cycles -> frame_err pulse at TIMEOUT; a subsequent full 1C frame decodes correctly.
- With 1C and 29 held: send AA -> key_down=0, no pulse. Then E1 14 77 E1 F0 14 F0 77 -> no events, FSM IDLE. Then assert rst_n=0 mid-frame -> all outputs 0 immediately.
